// File: rtl/manch_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : manch_frame_ctrl
// Description : Frame sequencer behind the Manchester decoder. Hunts for a
//               sync byte in the decoded bit stream, then walks the length,
//               payload and checksum fields, queues payload bytes in a small
//               output FIFO and reports per-frame status.
// Revision    : 1.0 - initial release
// ============================================================================
module manch_frame_ctrl #(
  parameter int         CLK_FREQ     = 18_750_000,
  parameter int         BAUDRATE     = 115200*2,
  parameter int         TIMEOUT_BITS = 4,
  parameter logic [7:0] SYNC_WORD    = 8'hD5,
  parameter int         MAX_LEN      = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [2:0] frame_err,
  output logic       busy
);

  localparam int BIT_CLKS     = 2 * (CLK_FREQ / BAUDRATE);
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;
  localparam int RW           = $clog2(MAX_LEN + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_TMO  = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_CSUM = 3'd3;
  localparam logic [2:0] ERR_OVF  = 3'd4;

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t          state_q,  state_d;
  // Only the seven previous bits are kept; the live bit completes each byte.
  logic [6:0]      hist_q,   hist_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      csum_q,   csum_d;
  logic [RW-1:0]   rem_q,    rem_d;
  logic            ovf_q,    ovf_d;
  logic [TW-1:0]   tmo_q,    tmo_d;
  logic            done_q,   done_d;
  logic [2:0]      err_q,    err_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic            w_bit, w_byte_done, w_pop, w_push, w_push_req;
  logic [7:0]      w_byte;

  assign w_bit       = enable & bit_valid;
  assign w_byte      = {hist_q, bit_data};
  assign w_byte_done = w_bit & (bitcnt_q == 3'd7);
  assign w_pop       = (cnt_q != '0) & out_ready;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_push      = w_push_req & ((cnt_q != FIFO_FULL) | w_pop);

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (cnt_q != '0);
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_HUNT);

  // Next-state logic: field sequencing, checksum, timeout and abort handling.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    bitcnt_d   = bitcnt_q;
    csum_d     = csum_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q + TW'(1);
    done_d     = 1'b0;
    err_d      = err_q;
    w_push_req = 1'b0;

    if (w_bit) begin
      hist_d   = w_byte[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
      tmo_d    = '0;
    end

    if (!enable) begin
      if (state_q != S_HUNT) begin
        done_d = 1'b1;
        err_d  = ERR_TMO;
      end
      state_d  = S_HUNT;
      bitcnt_d = '0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          if (w_bit && (w_byte == SYNC_WORD)) begin
            state_d  = S_LEN;
            bitcnt_d = '0;
            csum_d   = '0;
          end
        end
        S_LEN: begin
          if (w_byte_done) begin
            bitcnt_d = '0;
            if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
              done_d  = 1'b1;
              err_d   = ERR_LEN;
              state_d = S_HUNT;
            end else begin
              csum_d  = w_byte;
              rem_d   = RW'(w_byte);
              state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_byte_done) begin
            csum_d     = csum_q + w_byte;
            rem_d      = rem_q - RW'(1);
            w_push_req = 1'b1;
            if ((cnt_q == FIFO_FULL) && !w_pop) ovf_d = 1'b1;
            if (rem_q == RW'(1)) begin
              state_d  = S_CSUM;
              bitcnt_d = '0;
            end
          end
        end
        S_CSUM: begin
          if (w_byte_done) begin
            done_d   = 1'b1;
            err_d    = ovf_q ? ERR_OVF : ((w_byte != csum_q) ? ERR_CSUM : ERR_OK);
            state_d  = S_HUNT;
            bitcnt_d = '0;
            ovf_d    = 1'b0;
          end
        end
        default: state_d = S_HUNT;
      endcase

      // Silence abort; a bit arriving on the limit cycle keeps the frame alive.
      if ((state_q != S_HUNT) && !w_bit && (tmo_q == TMO_LAST)) begin
        done_d   = 1'b1;
        err_d    = ERR_TMO;
        state_d  = S_HUNT;
        bitcnt_d = '0;
        ovf_d    = 1'b0;
      end
    end

    if (state_d == S_HUNT) tmo_d = '0;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HUNT;
      hist_q   <= '0;
      bitcnt_q <= '0;
      csum_q   <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      bitcnt_q <= bitcnt_d;
      csum_q   <= csum_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_byte;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_manch_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_manch_frame_ctrl
// Description : Directed self-checking bench for manch_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_manch_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_done;
  logic [2:0] frame_err;
  logic       busy;

  manch_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         gap      = 162;
  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_bv  = 0;
  logic [2:0] last_err = 3'd0;
  logic [7:0] rxq [$];

  // Edge counter used to time frame_done against the last bit strobe.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: accepted bytes, frame_done pulses, strobe times.
  always @(negedge clk) begin
    if (bit_valid) last_bv = cyc + 1;
    if (out_valid && out_ready) rxq.push_back(out_data);
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      last_err = frame_err;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rx(input int i);
    if (i < rxq.size()) return int'(rxq[i]);
    return -1;
  endfunction

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_valid = 1'b1;
    bit_data  = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic clr();
    rxq.delete();
    done_cnt = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    settle(3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    settle(2);

    // Good frame at the nominal bit rate
    clr(); gap = 162;
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h02);
    check("ok_busy_mid", int'(busy), 1);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hE3);
    settle(5);
    check("ok_nbytes", rxq.size(), 2);
    check("ok_b0", rx(0), 'hA5);
    check("ok_b1", rx(1), 'h3C);
    check("ok_done_cnt", done_cnt, 1);
    check("ok_err", int'(last_err), 0);
    check("ok_busy", int'(busy), 0);

    // Wrong checksum
    clr(); gap = 24;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h55); send_byte(8'hD5);
    send_byte(8'h02); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h00);
    settle(5);
    check("cs_b0", rx(0), 'hA5);
    check("cs_b1", rx(1), 'h3C);
    check("cs_done_cnt", done_cnt, 1);
    check("cs_err", int'(frame_err), 3);

    // Length zero
    clr();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h00);
    settle(5);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_err", int'(last_err), 2);
    check("len0_at_8th_bit", done_cyc - last_bv, 0);
    check("len0_nbytes", rxq.size(), 0);

    // Length above maximum
    clr();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h11);
    settle(5);
    check("len17_done_cnt", done_cnt, 1);
    check("len17_err", int'(last_err), 2);
    check("len17_at_8th_bit", done_cyc - last_bv, 0);
    check("len17_nbytes", rxq.size(), 0);

    // Recovery frame after length errors
    clr();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h01);
    send_byte(8'h7E); send_byte(8'h7F);
    settle(5);
    check("rec_b0", rx(0), 'h7E);
    check("rec_nbytes", rxq.size(), 1);
    check("rec_err", int'(frame_err), 0);

    // Silence mid-payload
    clr(); gap = 162;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h03);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    settle(700);
    check("tmo_done_cnt", done_cnt, 1);
    check("tmo_err", int'(last_err), 1);
    check("tmo_delay", done_cyc - last_bv, 648);
    check("tmo_busy", int'(busy), 0);

    // Enable dropped mid-frame
    clr(); gap = 24;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h02);
    check("en_busy_before", int'(busy), 1);
    enable = 1'b0;
    settle(4);
    check("en_done_cnt", done_cnt, 1);
    check("en_err", int'(frame_err), 1);
    check("en_busy_after", int'(busy), 0);
    enable = 1'b1;

    // FIFO overflow with consumer stalled
    clr(); out_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h06);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_byte(8'h1B);
    settle(5);
    check("ovf_done_cnt", done_cnt, 1);
    check("ovf_err", int'(frame_err), 4);
    check("ovf_out_valid", int'(out_valid), 1);
    check("ovf_head", int'(out_data), 'h01);
    out_ready = 1'b1;
    settle(10);
    check("ovf_nbytes", rxq.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_b%0d", i), rx(i), i + 1);
    check("ovf_drained", int'(out_valid), 0);

    // Reset pulsed mid-payload with bytes queued
    clr(); out_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("rstm_queued", int'(out_valid), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstm_out_valid", int'(out_valid), 0);
    check("rstm_busy", int'(busy), 0);
    check("rstm_err", int'(frame_err), 0);
    settle(3);
    rst_n = 1'b1;
    settle(3);
    check("rstm_no_done", done_cnt, 0);
    out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hD5); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hE3);
    settle(5);
    check("rstm_b0", rx(0), 'hA5);
    check("rstm_b1", rx(1), 'h3C);
    check("rstm_done_cnt", done_cnt, 1);
    check("rstm_frame_err", int'(last_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/manch_frame_ctrl.md
Name: manch_frame_ctrl

Overview:
- Frame sequencer behind the Manchester decoder.
- Consumes the decoder's recovered bit stream as single-cycle bit strobes and hunts for a sync byte.
- Then sequences the length, payload and checksum fields, pushing payload bytes into a small output FIFO with a valid/ready handshake.
- Reports per-frame status (ok / timeout / bad length / checksum / overflow) to the downstream packet logic.

Parameters:
- CLK_FREQ, 18_750_000, system clock in Hz.
- BAUDRATE, 115200*2, Manchester chip rate in Hz. One data bit = 2 chips; bit period BIT_CLKS = 2*(CLK_FREQ/BAUDRATE) = 162 clocks.
- TIMEOUT_BITS, 4, mid-frame silence limit in bit periods. TIMEOUT_CLKS = TIMEOUT_BITS*BIT_CLKS = 648.
- SYNC_WORD, 8'hD5, sync byte, MSB first.
- MAX_LEN, 16, largest legal payload length in bytes.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  0 = forced to HUNT, bits ignored, FIFO still drains.
- bit_valid  in  1  one-cycle strobe: bit_data is a new decoded bit.
- bit_data  in  1  decoded bit value.
- out_data  out  8  payload byte at FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- frame_done  out  1  one-cycle pulse at end or abort of a frame.
- frame_err  out  3  status code, updated with frame_done and held until the next frame_done. 0 ok, 1 timeout, 2 bad length, 3 checksum, 4 overflow.
- busy  out  1  state != HUNT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=HUNT; shift register, bit counter, checksum, timeout counter, FIFO pointers and count cleared.
  - out_valid=0, out_data=0, frame_done=0, frame_err=0, busy=0.
  - Reset mid-frame discards the partial frame and all FIFO contents; no frame_done is produced.
- Bits are shifted MSB first into an 8-bit shift register on every bit_valid while enable=1.
- States:
  - HUNT: on every bit_valid, compare {shift[6:0],bit_data} with SYNC_WORD. On a match, go to LEN with bit counter=0 and checksum=0. Preamble bytes (e.g. 0x55) are ignored naturally.
  - LEN: on the 8th bit, byte L is formed.
    - L==0 or L>MAX_LEN: frame_done=1, frame_err=2, return to HUNT.
    - Otherwise: checksum=L, remaining=L, go to PAYLOAD.
  - PAYLOAD: on each 8th bit, byte B is formed.
    - checksum += B (mod 256) and remaining decrements.
    - B is written to the FIFO at the same clock edge.
    - If the FIFO is full and no pop occurs that cycle, B is dropped and a sticky overflow flag is set.
    - When remaining reaches 0, go to CSUM.
  - CSUM: on the 8th bit, frame_done=1.
    - frame_err = 4 if the overflow flag is set, else 3 if the byte != checksum, else 0.
    - Return to HUNT and clear the overflow flag.
- Bit counter is 3 bits and wraps at 8; it is cleared on entering any state.
- Timeout:
  - Counter clears on bit_valid and increments each clock while busy.
  - Reaching TIMEOUT_CLKS aborts: frame_done=1, frame_err=1, return to HUNT.
  - bit_valid in the same cycle wins (counter clears, no abort).
  - The counter is held at 0 in HUNT.
- enable deasserted while busy: immediate abort to HUNT with frame_done=1, frame_err=1.
- FIFO:
  - out_data and out_valid are registered; a byte written at edge N is visible at out_valid from cycle N+1.
  - Simultaneous push and pop is legal in any occupancy, including full.
  - Pop when empty is ignored.
  - Payload bytes are released before the checksum is known; downstream discards on frame_err!=0.
- frame_done is never asserted in two consecutive cycles. frame_err changes only with frame_done.

Test Plan:
- Stream 0x55,0x55,0xD5,0x02,0xA5,0x3C,0xE3 (bit_valid every 162 clocks, out_ready=1) -> out bytes A5 then 3C; one frame_done with frame_err=0; busy=0 afterwards.
- Same frame with checksum byte 0x00 -> A5 and 3C delivered; frame_done with frame_err=3.
- Sync then LEN=0x00, and separately LEN=0x11 (17 > MAX_LEN) -> frame_done with frame_err=2 on the 8th length bit; no FIFO writes; next valid frame is received correctly.
- Sync, LEN=0x03, then 4 payload bits followed by silence -> frame_done with frame_err=1 exactly 648 clocks after the last bit_valid; state returns to HUNT.
- out_ready=0, frame with LEN=6, payload 01..06, correct checksum 0x1B -> FIFO holds 01..04; frame_done with frame_err=4; raising out_ready drains exactly 01,02,03,04.
- rst_n pulsed low mid-PAYLOAD with 2 bytes queued -> out_valid=0 immediately; no frame_done; a subsequent full frame decodes with frame_err=0.
